// File: rtl/pipeline_fetch_control.sv
// pipeline_fetch_control
//   Front end of the 64-bit LEGv8 pipeline. It owns the fetch PC, the fetch
//   register (IR) and the decoder. B, CBZ and B.cond resolve in decode. A
//   taken branch squashes the slot behind it. A load followed by a dependent
//   consumer holds the front end for one bubble cycle.
//
//   Optional build macro: PIPELINE_FETCH_PERF_EN adds the stall and squash
//   event counters stall_cnt and squash_cnt, which saturate at all-ones.
//
// Ports
//   clk                       single clock, all state on posedge
//   reset                     synchronous, active-low
//   imem_addr   out  PC_W     fetch address (PC_F)
//   imem_data   in   32       instruction at imem_addr, same cycle
//   earlyZero   in   1        forwarded Rt==0 for CBZ
//   zero/negative/overflow/carry_out in   latched ALU flags for B.cond
//   instruction out  32       decode-stage word, or BUBBLE while stalled
//   Reg2Loc..weFlags, ALUOp   decoded controls (all zero on stall)
//   stall       out  1        load-use bubble this cycle
//   stall_cnt, squash_cnt     event counters (PIPELINE_FETCH_PERF_EN only)
module pipeline_fetch_control #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [31:0]     BUBBLE   = 32'h0000_03FF
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_data,
   input  logic            earlyZero,
   input  logic            zero,
   input  logic            negative,
   input  logic            overflow,
   input  logic            carry_out,
   output logic [31:0]     instruction,
   output logic            Reg2Loc,
   output logic            RegWrite,
   output logic            MemWrite,
   output logic            MemToReg,
   output logic            ALUSrc,
   output logic            weFlags,
   output logic [2:0]      ALUOp,
   output logic            stall
`ifdef PIPELINE_FETCH_PERF_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     squash_cnt
`endif
);

   logic [PC_W-1:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d;
   logic [31:0]     ir_q, ir_d;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic            ld_v_q, ld_v_d;

   logic            dec_r2l, dec_rw, dec_mw, dec_m2r, dec_as, dec_wf;
   logic [2:0]      dec_op;
   logic            rd_rn, rd_b, is_b, is_cbz, is_bcond;
   logic            cond_ok, taken;
   logic [4:0]      b_src;
   logic [PC_W-1:0] br_off;

   always_comb begin
      dec_r2l  = 1'b0;
      dec_rw   = 1'b0;
      dec_mw   = 1'b0;
      dec_m2r  = 1'b0;
      dec_as   = 1'b0;
      dec_wf   = 1'b0;
      dec_op   = 3'b000;
      rd_rn    = 1'b0;
      rd_b     = 1'b0;
      is_b     = 1'b0;
      is_cbz   = 1'b0;
      is_bcond = 1'b0;
      if (ir_q[31:22] == 10'b1001000100) begin          // ADDI
         dec_rw = 1'b1; dec_as = 1'b1; dec_op = 3'b010; rd_rn = 1'b1;
      end else if (ir_q[31:21] == 11'b10101011000) begin // ADDS
         dec_rw = 1'b1; dec_r2l = 1'b1; dec_wf = 1'b1; dec_op = 3'b010;
         rd_rn = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:21] == 11'b11101011000) begin // SUBS
         dec_rw = 1'b1; dec_r2l = 1'b1; dec_wf = 1'b1; dec_op = 3'b011;
         rd_rn = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:21] == 11'b10001010000) begin // AND
         dec_rw = 1'b1; dec_r2l = 1'b1; dec_op = 3'b100;
         rd_rn = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:21] == 11'b11001010000) begin // EOR
         dec_rw = 1'b1; dec_r2l = 1'b1; dec_op = 3'b110;
         rd_rn = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:21] == 11'b11010011010) begin // LSR (shamt, Rn only)
         dec_rw = 1'b1; dec_as = 1'b1; dec_op = 3'b001; rd_rn = 1'b1;
      end else if (ir_q[31:21] == 11'b11111000010) begin // LDUR
         dec_rw = 1'b1; dec_m2r = 1'b1; dec_as = 1'b1; dec_op = 3'b010;
         rd_rn = 1'b1;
      end else if (ir_q[31:21] == 11'b11111000000) begin // STUR reads Rt on port B
         dec_mw = 1'b1; dec_as = 1'b1; dec_op = 3'b010;
         rd_rn = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:26] == 6'b000101) begin
         is_b = 1'b1;
      end else if (ir_q[31:24] == 8'b10110100) begin     // CBZ tests Rt on port B
         is_cbz = 1'b1; rd_b = 1'b1;
      end else if (ir_q[31:24] == 8'b01010100) begin
         is_bcond = 1'b1;
      end
   end

   // Port B carries Rm for R-type, otherwise the Rt field.
   assign b_src = dec_r2l ? ir_q[20:16] : ir_q[4:0];

   // X31 is the zero register, so a load into it never creates a hazard.
   assign stall = ld_v_q && (ld_rd_q != 5'd31) &&
                  ((rd_rn && (ld_rd_q == ir_q[9:5])) || (rd_b && (ld_rd_q == b_src)));

   always_comb begin
      cond_ok = 1'b0;
      case (ir_q[3:0])
         4'h0: cond_ok = zero;
         4'h1: cond_ok = !zero;
         4'h2: cond_ok = carry_out;
         4'h3: cond_ok = !carry_out;
         4'hA: cond_ok = (negative == overflow);
         4'hB: cond_ok = (negative != overflow);
         4'hC: cond_ok = !zero && (negative == overflow);
         4'hD: cond_ok = zero || (negative != overflow);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // A stalled branch is re-evaluated next cycle with the forwarded operand.
   assign taken = !stall && (is_b || (is_cbz && earlyZero) || (is_bcond && cond_ok));

   assign br_off = is_b ? {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00}
                        : {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};

   always_comb begin
      pc_f_d  = pc_f_q;
      pc_d_d  = pc_d_q;
      ir_d    = ir_q;
      ld_rd_d = ir_q[4:0];
      ld_v_d  = !stall && dec_m2r;
      if (!stall) begin
         pc_d_d = pc_f_q;
         if (taken) begin
            pc_f_d = pc_d_q + br_off;
            ir_d   = BUBBLE;
         end else begin
            pc_f_d = pc_f_q + PC_W'(4);
            ir_d   = imem_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_f_q  <= RESET_PC;
         pc_d_q  <= '0;
         ir_q    <= BUBBLE;
         ld_rd_q <= 5'd0;
         ld_v_q  <= 1'b0;
      end else begin
         pc_f_q  <= pc_f_d;
         pc_d_q  <= pc_d_d;
         ir_q    <= ir_d;
         ld_rd_q <= ld_rd_d;
         ld_v_q  <= ld_v_d;
      end
   end

   assign imem_addr   = pc_f_q;
   assign instruction = stall ? BUBBLE : ir_q;
   assign Reg2Loc     = dec_r2l && !stall;
   assign RegWrite    = dec_rw  && !stall;
   assign MemWrite    = dec_mw  && !stall;
   assign MemToReg    = dec_m2r && !stall;
   assign ALUSrc      = dec_as  && !stall;
   assign weFlags     = dec_wf  && !stall;
   assign ALUOp       = stall ? 3'b000 : dec_op;

`ifdef PIPELINE_FETCH_PERF_EN
   logic [31:0] stall_cnt_q, squash_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (taken && (squash_cnt_q != 32'hFFFF_FFFF))
            squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign squash_cnt = squash_cnt_q;
`endif

endmodule
